// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer with branch/trap redirect and post-redirect flush window.
// Optional macro BRANCH_MISALIGN_CHECK_EN rejects taken branches to non-word-aligned targets.
module fetch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        stall_in,
   input  logic        branch_valid_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   input  logic        trap_in,
   input  logic [31:0] trap_vector_in,
   input  logic        imem_ack_in,
   output logic [31:0] pc_out,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   output logic        instr_valid_out,
   output logic        flush_out,
   output logic        misalign_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic [2:0] L_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [2:0]  r_flush_cnt;
   logic        r_instr_valid;
   logic        r_misalign;

   state_t      w_state_next;
   logic [31:0] w_pc_next;
   logic [2:0]  w_flush_cnt_next;
   logic        w_instr_valid_next;

   logic        w_active;
   logic        w_taken;
   logic        w_misalign;
   logic        w_redirect;
   logic [31:0] w_branch_tgt;
   logic [31:0] w_trap_tgt;
   logic [31:0] w_redirect_tgt;

   assign w_active = (r_state != S_IDLE);
   assign w_taken  = branch_valid_in && branch_taken_in;

`ifdef BRANCH_MISALIGN_CHECK_EN
   // A trap outranks the branch, so a misaligned branch only reports when it would have won.
   assign w_misalign   = w_active && w_taken && !trap_in && (branch_target_in[1:0] != 2'b00);
   assign w_branch_tgt = branch_target_in;
   assign w_trap_tgt   = trap_vector_in;
`else
   assign w_misalign   = 1'b0;
   assign w_branch_tgt = branch_target_in & 32'hFFFF_FFFC;
   assign w_trap_tgt   = trap_vector_in & 32'hFFFF_FFFC;
`endif

   assign w_redirect     = w_active && (trap_in || (w_taken && !w_misalign));
   assign w_redirect_tgt = trap_in ? w_trap_tgt : w_branch_tgt;

   always_comb begin
      w_state_next       = r_state;
      w_pc_next          = r_pc;
      w_flush_cnt_next   = r_flush_cnt;
      w_instr_valid_next = 1'b0;
      case (r_state)
         S_IDLE: w_state_next = S_FETCH;
         S_FETCH: begin
            if (imem_ack_in && !stall_in) begin
               w_pc_next          = r_pc + 32'd4;
               w_instr_valid_next = 1'b1;
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt == 3'd0) w_state_next = S_FETCH;
            else                     w_flush_cnt_next = r_flush_cnt - 3'd1;
         end
         default: w_state_next = S_IDLE;
      endcase
      // Redirect overrides everything, including a same-cycle ack.
      if (w_redirect) begin
         w_pc_next          = w_redirect_tgt;
         w_state_next       = S_FLUSH;
         w_flush_cnt_next   = L_FLUSH_INIT;
         w_instr_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_flush_cnt   <= 3'd0;
         r_instr_valid <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_flush_cnt   <= w_flush_cnt_next;
         r_instr_valid <= w_instr_valid_next;
         r_misalign    <= w_misalign;
      end
   end

   assign pc_out          = r_pc;
   assign imem_addr_out   = r_pc;
   assign imem_req_out    = (r_state == S_FETCH) && !stall_in;
   assign flush_out       = (r_state == S_FLUSH);
   assign instr_valid_out = r_instr_valid;
   assign misalign_out    = r_misalign;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: scenario tasks plus a scoreboard of expected PCs per accepted word.
module tb_fetch_redirect_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        stall_in;
   logic        branch_valid_in;
   logic        branch_taken_in;
   logic [31:0] branch_target_in;
   logic        trap_in;
   logic [31:0] trap_vector_in;
   logic        imem_ack_in;
   logic [31:0] pc_out;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        instr_valid_out;
   logic        flush_out;
   logic        misalign_out;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   fetch_redirect_ctrl #(.RESET_PC(32'h0000_1000), .FLUSH_CYCLES(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
      .branch_valid_in(branch_valid_in), .branch_taken_in(branch_taken_in),
      .branch_target_in(branch_target_in), .trap_in(trap_in),
      .trap_vector_in(trap_vector_in), .imem_ack_in(imem_ack_in),
      .pc_out(pc_out), .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
      .instr_valid_out(instr_valid_out), .flush_out(flush_out), .misalign_out(misalign_out)
   );

   always #5 clk_in = ~clk_in;

   // Each accepted word must match the oldest expected post-increment PC.
   always @(negedge clk_in) begin
      if (!rst_in && instr_valid_out) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_valid: got valid with pc=%h, required no valid", pc_out);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            $display("txn accepted word, pc now %h (expected %h)", pc_out, e);
            if (pc_out !== e) begin
               bad++;
               $display("FAIL sb_pc: got %h required %h", pc_out, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_inputs();
      stall_in = 0; branch_valid_in = 0; branch_taken_in = 0;
      branch_target_in = 0; trap_in = 0; trap_vector_in = 0; imem_ack_in = 0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      clear_inputs();
      #2;
      total++; if (pc_out !== 32'h1000) begin bad++; $display("FAIL reset_pc: got %h required %h", pc_out, 32'h1000); end
      total++; if ({imem_req_out, instr_valid_out, flush_out, misalign_out} !== 4'b0000) begin
         bad++; $display("FAIL reset_outs: got %b required 0000", {imem_req_out, instr_valid_out, flush_out, misalign_out});
      end
      step(); step();
      rst_in = 1'b0;
      total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL boot_idle_req: got %b required 0", imem_req_out); end
      step();
      total++; if (imem_req_out !== 1'b1) begin bad++; $display("FAIL boot_req: got %b required 1", imem_req_out); end
      total++; if (imem_addr_out !== 32'h1000) begin bad++; $display("FAIL boot_addr: got %h required %h", imem_addr_out, 32'h1000); end
   endtask

   task automatic test_seq_fetch();
      logic [31:0] m_pc;
      m_pc = 32'h1000;
      for (int i = 0; i < 3; i++) begin
         imem_ack_in = 1'b1;
         m_pc = m_pc + 32'd4;
         exp_q.push_back(m_pc);
         step();
      end
      imem_ack_in = 1'b0;
      total++; if (pc_out !== 32'h100C) begin bad++; $display("FAIL seq_pc: got %h required %h", pc_out, 32'h100C); end
      stall_in = 1'b1; imem_ack_in = 1'b1;
      #1;
      total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL stall_req: got %b required 0", imem_req_out); end
      step(); step();
      total++; if (pc_out !== 32'h100C) begin bad++; $display("FAIL stall_pc: got %h required %h", pc_out, 32'h100C); end
      clear_inputs();
      #1;
      total++; if (imem_req_out !== 1'b1) begin bad++; $display("FAIL unstall_req: got %b required 1", imem_req_out); end
   endtask

   task automatic test_taken_branch();
      branch_valid_in = 1; branch_taken_in = 1; branch_target_in = 32'h2000; imem_ack_in = 1;
      step();
      clear_inputs();
      total++; if (pc_out !== 32'h2000) begin bad++; $display("FAIL br_pc: got %h required %h", pc_out, 32'h2000); end
      total++; if (flush_out !== 1'b1) begin bad++; $display("FAIL br_flush0: got %b required 1", flush_out); end
      total++; if (imem_req_out !== 1'b0) begin bad++; $display("FAIL br_req_in_flush: got %b required 0", imem_req_out); end
      step();
      total++; if (flush_out !== 1'b1) begin bad++; $display("FAIL br_flush1: got %b required 1", flush_out); end
      step();
      total++; if (flush_out !== 1'b0) begin bad++; $display("FAIL br_flush_end: got %b required 0", flush_out); end
      total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h2000) begin
         bad++; $display("FAIL br_refetch: got req=%b addr=%h required req=1 addr=%h", imem_req_out, imem_addr_out, 32'h2000);
      end
      branch_valid_in = 1; branch_taken_in = 0; branch_target_in = 32'h5000;
      step();
      clear_inputs();
      total++; if (pc_out !== 32'h2000 || flush_out !== 1'b0) begin
         bad++; $display("FAIL not_taken: got pc=%h flush=%b required pc=%h flush=0", pc_out, flush_out, 32'h2000);
      end
   endtask

   task automatic test_priority();
      trap_in = 1; trap_vector_in = 32'h100;
      branch_valid_in = 1; branch_taken_in = 1; branch_target_in = 32'h3000;
      step();
      clear_inputs();
      total++; if (pc_out !== 32'h100) begin bad++; $display("FAIL prio_pc: got %h required %h", pc_out, 32'h100); end
      branch_valid_in = 1; branch_taken_in = 1; branch_target_in = 32'h4000;
      step();
      clear_inputs();
      total++; if (pc_out !== 32'h4000 || flush_out !== 1'b1) begin
         bad++; $display("FAIL reflush_pc: got pc=%h flush=%b required pc=%h flush=1", pc_out, flush_out, 32'h4000);
      end
      step();
      total++; if (flush_out !== 1'b1) begin bad++; $display("FAIL reflush_hold: got %b required 1", flush_out); end
      step();
      total++; if (flush_out !== 1'b0 || imem_addr_out !== 32'h4000 || imem_req_out !== 1'b1) begin
         bad++; $display("FAIL reflush_end: got flush=%b req=%b addr=%h required flush=0 req=1 addr=%h", flush_out, imem_req_out, imem_addr_out, 32'h4000);
      end
   endtask

   task automatic test_wrap();
      trap_in = 1; trap_vector_in = 32'hFFFF_FFFC;
      step();
      clear_inputs();
      step(); step();
      imem_ack_in = 1;
      exp_q.push_back(32'h0000_0000);
      step();
      clear_inputs();
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h required %h", pc_out, 32'h0); end
   endtask

   task automatic test_misalign();
      branch_valid_in = 1; branch_taken_in = 1; branch_target_in = 32'h2002; imem_ack_in = 1;
`ifdef BRANCH_MISALIGN_CHECK_EN
      exp_q.push_back(32'h4);
`endif
      step();
      clear_inputs();
`ifdef BRANCH_MISALIGN_CHECK_EN
      total++; if (misalign_out !== 1'b1 || flush_out !== 1'b0 || pc_out !== 32'h4) begin
         bad++; $display("FAIL misalign_on: got mis=%b flush=%b pc=%h required mis=1 flush=0 pc=%h", misalign_out, flush_out, pc_out, 32'h4);
      end
      step();
      total++; if (misalign_out !== 1'b0) begin bad++; $display("FAIL misalign_pulse: got %b required 0", misalign_out); end
`else
      total++; if (misalign_out !== 1'b0 || flush_out !== 1'b1 || pc_out !== 32'h2000) begin
         bad++; $display("FAIL misalign_off: got mis=%b flush=%b pc=%h required mis=0 flush=1 pc=%h", misalign_out, flush_out, pc_out, 32'h2000);
      end
      step(); step();
      total++; if (flush_out !== 1'b0 || imem_addr_out !== 32'h2000) begin
         bad++; $display("FAIL misalign_off_end: got flush=%b addr=%h required flush=0 addr=%h", flush_out, imem_addr_out, 32'h2000);
      end
`endif
   endtask

   task automatic test_reset_mid_flush();
      trap_in = 1; trap_vector_in = 32'h500;
      step();
      clear_inputs();
      total++; if (flush_out !== 1'b1) begin bad++; $display("FAIL pre_rst_flush: got %b required 1", flush_out); end
      #2;
      rst_in = 1'b1;
      #1;
      total++; if (pc_out !== 32'h1000) begin bad++; $display("FAIL rst_async_pc: got %h required %h", pc_out, 32'h1000); end
      total++; if ({imem_req_out, instr_valid_out, flush_out, misalign_out} !== 4'b0000) begin
         bad++; $display("FAIL rst_async_outs: got %b required 0000", {imem_req_out, instr_valid_out, flush_out, misalign_out});
      end
      step();
      rst_in = 1'b0;
      step();
      total++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h1000) begin
         bad++; $display("FAIL rst_reboot: got req=%b addr=%h required req=1 addr=%h", imem_req_out, imem_addr_out, 32'h1000);
      end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_taken_branch();
      test_priority();
      test_wrap();
      test_misalign();
      test_reset_mid_flush();
      step();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending required 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

- Sequences the instruction-fetch PC and redirects it when the execute stage resolves a taken branch/jump (driven by `branch_unit`'s `branch_taken_out`) or a trap.
- Runs a request/acknowledge handshake with instruction memory and flushes the younger in-flight instructions for a fixed number of cycles after each redirect.
- Sits between the EX-stage branch logic, the trap logic and the IF stage of the RV32 core.

## Interface

Clock is `clk_in`; reset is `rst_in`, asynchronous and active-high.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `FLUSH_CYCLES`, default 2: cycles `flush_out` is held after a redirect. Legal range 1–7.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: asynchronous active-high reset.
- `stall_in` in 1: pipeline stall; holds PC, suppresses fetch.
- `branch_valid_in` in 1: EX stage holds a resolved branch/jump this cycle.
- `branch_taken_in` in 1: resolution result (from `branch_unit`).
- `branch_target_in` in 32: redirect target for a taken branch.
- `trap_in` in 1: trap request.
- `trap_vector_in` in 32: trap target.
- `imem_ack_in` in 1: instruction memory has returned the word for `imem_addr_out`.
- `pc_out` out 32: current fetch PC.
- `imem_req_out` out 1: fetch request.
- `imem_addr_out` out 32: fetch address; always equals `pc_out`.
- `instr_valid_out` out 1: one-cycle pulse when a fetched word is accepted.
- `flush_out` out 1: kill IF/ID contents.
- `misalign_out` out 1: one-cycle pulse on a misaligned branch target (see Configuration).

## Operation

- **States:** IDLE, FETCH, FLUSH. A 3-bit `flush_cnt` counts the flush cycles.
- **Reset:** state = IDLE, `pc_out` = RESET_PC, `flush_cnt` = 0. All of `imem_req_out`, `instr_valid_out`, `flush_out` and `misalign_out` are 0.
- **IDLE:**
  - Moves to FETCH on the first clock after reset is released.
  - Outputs stay idle.
- **FETCH:**
  - `imem_req_out` = !`stall_in`.
  - On `imem_ack_in` && !`stall_in`: `pc_out` <= `pc_out` + 4 (wraps modulo 2^32) and `instr_valid_out` pulses.
  - `imem_ack_in` is ignored while stalled.
- **Redirect condition:** `trap_in`, or (`branch_valid_in` && `branch_taken_in`).
  - Evaluated in every state except IDLE.
  - Evaluated regardless of `stall_in`.
- **Priority:** trap > branch > sequential increment.
  - A trap loads `trap_vector_in`; a taken branch loads `branch_target_in`.
  - If an ack arrives in the same cycle as a redirect, the acked word is discarded and `instr_valid_out` stays 0.
- **On redirect:**
  - `pc_out` <= target, state <= FLUSH, `flush_cnt` <= FLUSH_CYCLES − 1.
  - `flush_out` is registered high starting the next cycle.
- **FLUSH:**
  - `flush_out` = 1 and `imem_req_out` = 0; `flush_cnt` decrements each cycle.
  - When `flush_cnt` = 0, return to FETCH.
  - A new redirect during FLUSH reloads `pc_out` and restarts `flush_cnt` at FLUSH_CYCLES − 1.
- **Not-taken branch** (`branch_valid_in` = 1, `branch_taken_in` = 0): no effect.
- **Reset asserted mid-operation:** immediately forces reset values, from any state and any `flush_cnt`.

## Timing

- Redirect sampled at edge N:
  - After edge N: `pc_out` = target.
  - `flush_out` is high for exactly FLUSH_CYCLES cycles following edge N.
  - `imem_req_out` is next high in the cycle after `flush_out` falls, with `imem_addr_out` = target.
- Ack at edge N: `instr_valid_out` is high for the cycle after N, and `pc_out` has already advanced.
- Back-to-back acks give one instruction per cycle.
- After reset release: one IDLE cycle, then `imem_req_out` = 1 with `imem_addr_out` = RESET_PC.

## Configuration

Macro: `BRANCH_MISALIGN_CHECK_EN`.

- **Defined:**
  - A taken branch whose `branch_target_in[1:0]` ≠ 0 does not redirect and pulses `misalign_out` for one cycle.
  - Fetch continues sequentially, and no flush is issued.
  - Trap vectors are not checked.
- **Undefined:**
  - `misalign_out` is tied 0.
  - Branch and trap targets are loaded with bits [1:0] forced to 00.

## Test plan

- **Reset/boot:** assert `rst_in` mid-FLUSH with RESET_PC = 32'h0000_1000, then release.
  - All outputs go to 0 and `pc_out` = 32'h1000 asynchronously.
  - One cycle later, `imem_req_out` = 1 and `imem_addr_out` = 32'h1000.
- **Sequential fetch:** ack on 3 consecutive cycles starting at PC 32'h1000.
  - 3 `instr_valid_out` pulses; `pc_out` ends at 32'h100C.
  - Raising `stall_in` holds the PC and drops `imem_req_out`.
- **Taken branch:** `branch_valid_in` = 1, `branch_taken_in` = 1, target 32'h2000, with a simultaneous ack.
  - No `instr_valid_out`; `pc_out` = 32'h2000.
  - `flush_out` is high for 2 cycles, then `imem_req_out` = 1 with address 32'h2000.
  - A not-taken branch produces no change.
- **Priority:** trap (vector 32'h0000_0100) and taken branch (target 32'h3000) in the same cycle → `pc_out` = 32'h100.
  - A second branch to 32'h4000 during FLUSH → `pc_out` = 32'h4000 and the flush restarts for a full 2 cycles.
- **Wrap:** PC 32'hFFFF_FFFC acked → `pc_out` = 32'h0000_0000.
- **Misalign:** taken branch to 32'h2002.
  - With the macro: `misalign_out` pulses, no flush, PC stays sequential.
  - Without the macro: `pc_out` = 32'h2000 and a flush occurs.
